// File: rtl/cl_to_word_fifo.sv
// cl_to_word_fifo: 512-bit line in, 64-bit word out FIFO.
// Registered read data with a credit-style almost_full.
module cl_to_word_fifo #(
  parameter int DEPTH_LINES = 8,
  parameter int AFULL_LINES = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [511:0]                   wr_data,
  input  logic                           rd_en,
  output logic [63:0]                    rd_data,
  output logic                           rd_valid,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full,
  output logic [$clog2(DEPTH_LINES):0]   line_count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = $clog2(DEPTH_LINES);
  localparam int PW = AW + 1;

  logic [511:0]  mem [DEPTH_LINES];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    word_idx;
  logic          do_wr;
  logic          do_rd;
  logic [63:0]   head_word;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign line_count  = wr_ptr - rd_ptr;
  assign almost_full = (line_count >= PW'(AFULL_LINES));

  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_en && !empty;
  assign head_word = mem[rd_ptr[AW-1:0]][{word_idx, 6'b0} +: 64];

  always_ff @(posedge clk) begin
    if (!reset && do_wr)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      word_idx  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + PW'(1);
      else if (wr_en)
        overflow <= 1'b1;

      if (do_rd) begin
        rd_data  <= head_word;
        rd_valid <= 1'b1;
        word_idx <= word_idx + 3'd1;
        // last word of the head line frees it on this edge
        if (word_idx == 3'd7)
          rd_ptr <= rd_ptr + PW'(1);
      end else begin
        rd_valid <= 1'b0;
        if (rd_en)
          underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cl_to_word_fifo.sv
// tb_cl_to_word_fifo: directed + random checks against a
// word-queue reference model of cl_to_word_fifo.
module tb_cl_to_word_fifo;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [511:0] wr_data;
  logic         rd_en;
  logic [63:0]  rd_data;
  logic         rd_valid;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic [3:0]   line_count;
  logic         overflow;
  logic         underflow;

  cl_to_word_fifo #(.DEPTH_LINES(DEPTH), .AFULL_LINES(AFULL)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .almost_full(almost_full),
    .line_count(line_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q[$];
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ovf;
  logic        m_unf;

  function automatic int m_lines();
    return (q.size() + 7) / 8;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int ln;
    ln = m_lines();
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_valid));
    chk({tag, ".rd_data"}, rd_data, m_data);
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, ".full"}, 64'(full), 64'(ln == DEPTH));
    chk({tag, ".afull"}, 64'(almost_full), 64'(ln >= AFULL));
    chk({tag, ".line_count"}, 64'(line_count), 64'(ln));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
  endtask

  task automatic step(input logic rst, input logic wr,
                      input logic [511:0] d, input logic rd);
    bit pre_full;
    bit pre_empty;
    reset   = rst;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    pre_full  = (m_lines() == DEPTH);
    pre_empty = (q.size() == 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (rd) begin
        if (pre_empty) m_unf = 1'b1;
        else begin
          m_data  = q.pop_front();
          m_valid = 1'b1;
        end
      end
      if (wr) begin
        if (pre_full) m_ovf = 1'b1;
        else
          for (int k = 0; k < 8; k++) q.push_back(d[64*k +: 64]);
      end
    end
    #1;
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  logic [511:0] pat;
  int pushed;
  int cyc;

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    q.delete();
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // 1: reset with busy inputs
    step(1'b1, 1'b1, rnd_line(), 1'b1);
    step(1'b1, 1'b1, rnd_line(), 1'b1);
    check_all("rst");
    chk("rst.empty_const", 64'(empty), 64'd1);

    // 2: counting pattern, words 1..8 in order
    for (int k = 0; k < 8; k++) pat[64*k +: 64] = 64'(k + 1);
    step(1'b0, 1'b1, pat, 1'b0);
    check_all("pat.push");
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("pat.word", rd_data, 64'(k + 1));
      check_all("pat.pop");
    end
    step(1'b0, 1'b0, '0, 1'b0);
    check_all("pat.idle");

    // 3: fill, overflow, drain
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, rnd_line(), 1'b0);
      check_all("fill");
    end
    chk("fill.ovf_const", 64'(overflow), 64'd1);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check_all("drain");
    end

    // 4: underflow, then push+pop on empty
    step(1'b0, 1'b0, '0, 1'b1);
    check_all("unf");
    step(1'b0, 1'b1, rnd_line(), 1'b1);
    check_all("unf.push");
    chk("unf.lc_const", 64'(line_count), 64'd1);

    // 5: three lines, push while popping head word 7
    step(1'b0, 1'b1, rnd_line(), 1'b0);
    step(1'b0, 1'b1, rnd_line(), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
    check_all("w7.pre");
    step(1'b0, 1'b1, rnd_line(), 1'b1);
    check_all("w7.swap");
    chk("w7.lc_const", 64'(line_count), 64'd3);

    // 5b: random streaming of 100 lines
    pushed = 0;
    cyc = 0;
    while ((pushed < 100 || q.size() != 0) && cyc < 6000) begin
      logic w;
      logic r;
      w = (pushed < 100) && ($urandom_range(3) != 0) && (m_lines() < DEPTH);
      r = ($urandom_range(4) != 0) && (q.size() != 0);
      step(1'b0, w, rnd_line(), r);
      if (w) pushed++;
      check_all("stream");
      cyc++;
    end
    chk("stream.drained", 64'(q.size()), 64'd0);

    // 6: reset mid-line
    step(1'b0, 1'b1, rnd_line(), 1'b0);
    step(1'b0, 1'b1, rnd_line(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    check_all("mid.pre");
    step(1'b1, 1'b0, '0, 1'b0);
    check_all("mid.rst");
    pat = rnd_line();
    step(1'b0, 1'b1, pat, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    check_all("mid.first");
    chk("mid.word0", rd_data, pat[63:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
